// File: rtl/shift_seq_ctrl.sv
// Sequencing controller for an external parallel-load / shift-left register.
// Accepts a word, strobes load + N shifts, then returns the shifted-in word.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CNT_W      = $clog2(WIDTH + 1),
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic [CNT_W-1:0] tx_len,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  input  logic             abort,
  input  logic             ovr_clr,
  output logic             overrun,
  output logic             busy,
  output logic             frame,
  output logic             sr_load,
  output logic             sr_shift_en,
  output logic [WIDTH-1:0] sr_parallel_in,
  input  logic [WIDTH-1:0] sr_q
);

  localparam int unsigned      GAP_W    = 8;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CAPTURE,
    ST_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] pin_q, pin_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [WIDTH-1:0] rx_mask;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic             tx_ready_q, tx_ready_d;
  logic             busy_q, busy_d;
  logic             frame_q, frame_d;
  logic             sr_load_q, sr_load_d;
  logic             sr_shift_en_q, sr_shift_en_d;
  logic             capture;

  // Keep only the len_q bits that were actually shifted in.
  always_comb begin
    rx_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      rx_mask[i] = (i < 32'(len_q));
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    pin_d     = pin_q;
    capture   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          pin_d   = tx_data;
          len_d   = ((tx_len == '0) || (tx_len > LEN_MAX)) ? LEN_MAX : tx_len;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bit_cnt_d = '0;
        state_d   = abort ? ST_IDLE : ST_SHIFT;
      end
      ST_SHIFT: begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bit_cnt_q == (len_q - CNT_W'(1))) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // Abort wins over capture: the word is dropped without touching rx.
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          capture   = 1'b1;
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rx channel: a capture may consume and replace in the same edge; set beats clear.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (ovr_clr) begin
      overrun_d = 1'b0;
    end
    if (capture) begin
      rx_data_d  = sr_q & rx_mask;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    tx_ready_d    = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    frame_d       = (state_d == ST_SHIFT);
    sr_shift_en_d = (state_d == ST_SHIFT);
    sr_load_d     = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      len_q         <= LEN_MAX;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      pin_q         <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      overrun_q     <= 1'b0;
      tx_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
      frame_q       <= 1'b0;
      sr_load_q     <= 1'b0;
      sr_shift_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      pin_q         <= pin_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      overrun_q     <= overrun_d;
      tx_ready_q    <= tx_ready_d;
      busy_q        <= busy_d;
      frame_q       <= frame_d;
      sr_load_q     <= sr_load_d;
      sr_shift_en_q <= sr_shift_en_d;
    end
  end

  assign tx_ready       = tx_ready_q;
  assign rx_valid       = rx_valid_q;
  assign rx_data        = rx_data_q;
  assign overrun        = overrun_q;
  assign busy           = busy_q;
  assign frame          = frame_q;
  assign sr_load        = sr_load_q;
  assign sr_shift_en    = sr_shift_en_q;
  assign sr_parallel_in = pin_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomized bench for shift_seq_ctrl: two environments (GAP 0 and GAP 2),
// each with its own shift register model, word scoreboard and cycle-level checker.
module tb_shift_seq_ctrl;

  localparam int unsigned W    = 8;
  localparam int unsigned CW   = $clog2(W + 1);
  localparam int          NCYC = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit done [2];

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s env%0d t=%0t actual=0x%0h required=0x%0h", name, inst, $time, act, exp);
    end
  endtask

  function automatic int eff_len(input logic [CW-1:0] l);
    return ((l == '0) || (32'(l) > W)) ? int'(W) : int'(l);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_env
    localparam int GAP = 2 * g;

    logic          rst_n, tx_valid, tx_ready, rx_valid, rx_ready, abort, ovr_clr;
    logic          overrun, busy, frame, sr_load, sr_shift_en, serial_in;
    logic [W-1:0]  tx_data, rx_data, sr_parallel_in, sr_q;
    logic [CW-1:0] tx_len;
    logic [W-1:0]  reg_q    = '0;
    logic [W-1:0]  shadow_q = '0;
    logic [W-1:0]  offer_inj, fly_al;
    bit            offer_loop, fly_loop;

    shift_seq_ctrl #(.WIDTH(W), .GAP_CYCLES(GAP)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .tx_data        (tx_data),
      .tx_len         (tx_len),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .rx_data        (rx_data),
      .abort          (abort),
      .ovr_clr        (ovr_clr),
      .overrun        (overrun),
      .busy           (busy),
      .frame          (frame),
      .sr_load        (sr_load),
      .sr_shift_en    (sr_shift_en),
      .sr_parallel_in (sr_parallel_in),
      .sr_q           (sr_q)
    );

    // External register; serial_in is either loopback or an injected word, MSB-aligned.
    assign sr_q      = reg_q;
    assign serial_in = fly_loop ? reg_q[W-1] : shadow_q[W-1];
    always @(posedge clk) begin
      if (sr_load) begin
        reg_q    <= sr_parallel_in;
        shadow_q <= fly_al;
      end else if (sr_shift_en) begin
        reg_q    <= {reg_q[W-2:0], serial_in};
        shadow_q <= shadow_q << 1;
      end
    end

    // Stimulus: inputs change 1 time unit after each rising edge.
    initial begin
      bit           hs, hs_loop;
      int           hs_len;
      logic [W-1:0] hs_inj;
      hs = 1'b0; hs_loop = 1'b1; hs_len = int'(W); hs_inj = '0;
      rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_len = '0;
      rx_ready = 1'b0; abort = 1'b0; ovr_clr = 1'b0;
      offer_loop = 1'b1; offer_inj = '0; fly_loop = 1'b1; fly_al = '0;
      for (int i = 0; i < NCYC; i++) begin
        @(posedge clk);
        #1;
        if (hs) begin
          fly_loop = hs_loop;
          fly_al   = hs_inj << (int'(W) - hs_len);
        end
        rst_n      = (i < 3) ? 1'b0 : ($urandom_range(0, 399) != 0);
        tx_valid   = ($urandom_range(0, 3) != 0);
        tx_data    = W'($urandom);
        tx_len     = CW'($urandom_range(0, 15));
        offer_loop = ($urandom_range(0, 1) == 1);
        offer_inj  = W'($urandom);
        if ($urandom_range(0, 15) == 0) rx_ready = !rx_ready;
        abort      = ($urandom_range(0, 39) == 0);
        ovr_clr    = ($urandom_range(0, 9) == 0);
        hs = tx_valid && (tx_ready === 1'b1) && rst_n;
        if (hs) begin
          hs_len  = eff_len(tx_len);
          hs_loop = offer_loop;
          hs_inj  = offer_inj;
        end
      end
      done[g] = 1'b1;
    end

    // Reference: word timeline from the handshake cycle plus an rx-channel model.
    bit           started  = 1'b0;
    bit           have_cur = 1'b0;
    bit           m_valid  = 1'b0;
    bit           m_ovr    = 1'b0;
    logic [W-1:0] m_data   = '0;
    logic [W-1:0] m_pin    = '0;
    logic [W-1:0] cur_tx   = '0;
    int           cyc      = 0;
    int           cur_h    = 0;
    int           cur_len  = int'(W);
    logic [W-1:0] exp_q [$];

    always @(negedge clk) begin
      int           rel, l;
      bit           ld, sh, cp, bz, ab, nv, no;
      logic [W-1:0] nd, msk;
      rel = cyc - cur_h;
      ld  = have_cur && (rel == 1);
      sh  = have_cur && (rel >= 2) && (rel <= cur_len + 1);
      cp  = have_cur && (rel == cur_len + 2);
      bz  = have_cur && (rel >= 1) && (rel <= cur_len + 2 + GAP);
      if (started) begin
        chk("tx_ready", g, 32'(tx_ready), 32'(!bz));
        chk("busy", g, 32'(busy), 32'(bz));
        chk("sr_load", g, 32'(sr_load), 32'(ld));
        chk("sr_shift_en", g, 32'(sr_shift_en), 32'(sh));
        chk("frame", g, 32'(frame), 32'(sh));
        chk("sr_parallel_in", g, 32'(sr_parallel_in), 32'(m_pin));
        if (sh) chk("serial_out", g, 32'(reg_q[W-1]), 32'(cur_tx[W+1-rel]));
        chk("rx_valid", g, 32'(rx_valid), 32'(m_valid));
        chk("rx_data", g, 32'(rx_data), 32'(m_data));
        chk("overrun", g, 32'(overrun), 32'(m_ovr));
      end
      if (!rst_n) begin
        started  = 1'b1;
        have_cur = 1'b0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_data   = '0;
        m_pin    = '0;
        exp_q.delete();
      end else if (started) begin
        ab = abort && (ld || sh || cp);
        nv = m_valid && !rx_ready;
        nd = m_data;
        no = m_ovr && !ovr_clr;
        if (cp && !ab) begin
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty env%0d t=%0t actual=0 required=1", g, $time);
          end else begin
            nd = exp_q.pop_front();
            nv = 1'b1;
            if (m_valid && !rx_ready) no = 1'b1;
          end
        end
        if (ab) begin
          have_cur = 1'b0;
          exp_q.delete();
        end else if (have_cur && (rel >= cur_len + 2 + GAP)) begin
          have_cur = 1'b0;
        end
        if (!bz && tx_valid) begin
          l        = eff_len(tx_len);
          have_cur = 1'b1;
          cur_h    = cyc;
          cur_len  = l;
          cur_tx   = tx_data;
          m_pin    = tx_data;
          msk      = W'((32'd1 << l) - 32'd1);
          exp_q.push_back(offer_loop ? (tx_data >> (int'(W) - l)) : (offer_inj & msk));
        end
        m_valid = nv;
        m_data  = nd;
        m_ovr   = no;
      end
      cyc++;
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (!(done[0] && done[1]) && (waited < NCYC + 100)) begin
      @(posedge clk);
      waited++;
    end
    if (!(done[0] && done[1])) begin
      failures++;
      $display("FAIL stimulus_timeout actual=%0d required=%0d", waited, NCYC);
    end
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencing controller for the 8-bit parallel-load/shift-left register (MSB-first serial out, serial in at LSB).
- Accepts a transmit word on a valid/ready handshake.
- Drives the register's load and shift-enable strobes for a programmable bit count.
- Captures the shifted-in word and returns it on a second valid/ready channel.
- Sits between a host/FIFO and the register, forming a full-duplex serializer.

Parameters:
WIDTH, 8, shift register width; must match the register.
CNT_W, $clog2(WIDTH+1), bit counter width (derived; do not override).
GAP_CYCLES, 0, idle cycles inserted after each word before tx_ready returns high (0..255).

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  synchronous, active-low reset.
tx_valid  in  1  transmit word offered.
tx_ready  out  1  controller can accept a word.
tx_data  in  WIDTH  word to serialize.
tx_len  in  CNT_W  bits to shift (1..WIDTH); 0 or >WIDTH means WIDTH; sampled at handshake.
rx_valid  out  1  received word available.
rx_ready  in  1  consumer accepts rx_data.
rx_data  out  WIDTH  received word.
abort  in  1  synchronous abort of the word in flight.
ovr_clr  in  1  clears overrun.
overrun  out  1  sticky: rx word lost.
busy  out  1  high in any state except IDLE.
frame  out  1  high while shifting; serial_out is valid data while high.
sr_load  out  1  to register load.
sr_shift_en  out  1  to register shift_en.
sr_parallel_in  out  WIDTH  to register parallel_in.
sr_q  in  WIDTH  from register q.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - tx_ready=1 from the first cycle after reset.
  - rx_valid=0, rx_data=0, overrun=0, busy=0, frame=0, sr_load=0, sr_shift_en=0, sr_parallel_in=0.
  - Reset mid-word discards the word; no rx_valid is produced.
- Outputs are Moore-decoded from registered state and registered data; there is no combinational path from any input to any output.
- States:
  - IDLE: tx_ready=1. On tx_valid&tx_ready: latch tx_data into sr_parallel_in and the effective length into len_q. Next state LOAD.
  - LOAD (1 cycle): sr_load=1. Clear bit_cnt. Next state SHIFT.
  - SHIFT (len_q cycles): sr_shift_en=1, frame=1, bit_cnt++. When bit_cnt==len_q-1, next state CAPTURE.
  - CAPTURE (1 cycle): sr_q holds the final value. At the end of the cycle: rx_data <= sr_q & ((1<<len_q)-1), rx_valid <= 1. Next state GAP if GAP_CYCLES>0, else IDLE.
  - GAP: count GAP_CYCLES cycles, then IDLE.
- Timing, with handshake at the edge ending cycle 0:
  - LOAD in cycle 1.
  - SHIFT in cycles 2..len+1.
  - CAPTURE in cycle len+2.
  - rx_valid=1 and tx_ready=1 (GAP=0) from cycle len+3.
  - Minimum word period is len+3 cycles; no overlap of words.
- Serial order: in SHIFT cycle k (k=0..len-1), the register's serial_out carries tx_data[WIDTH-1-k]. The serial_in value sampled at the end of that cycle lands in rx_data[len-1-k].
- rx channel:
  - rx_valid holds with rx_data stable until rx_valid&rx_ready; it clears at that edge.
  - If CAPTURE completes while rx_valid=1 and rx_ready=0: rx_data is overwritten with the new word, rx_valid stays 1, and overrun is set.
  - If rx_ready=1 in the CAPTURE-end cycle, the old word is consumed and the new word loaded in the same edge, with no overrun.
- overrun is cleared by ovr_clr. If set and clear occur in the same cycle, set wins.
- abort:
  - In LOAD, SHIFT or CAPTURE: next state IDLE immediately; strobes drop the next cycle; no rx update, no overrun; GAP is skipped.
  - In IDLE or GAP: ignored.
  - Abort in the CAPTURE cycle takes priority over capture.
- tx_len is sampled only at the handshake; changes during a word have no effect.
- sr_parallel_in holds the last accepted word until the next handshake.

Test Plan:
- Loopback (serial_in=serial_out), GAP=0, tx_data=0xA5, tx_len=0 -> sr_load in cycle 1; serial_out=1,0,1,0,0,1,0,1 in cycles 2..9 with frame=1; rx_valid=1 and rx_data=0xA5 from cycle 11; tx_ready=1 in cycle 11.
- tx_data=0xF0, tx_len=3, serial_in held 1 -> exactly 3 sr_shift_en cycles; serial_out=1,1,1; rx_data=0x07.
- rx_ready=0, two back-to-back words 0x3C then 0xC3 (loopback) -> after the second word, rx_data=0xC3, overrun=1; assert ovr_clr -> overrun=0 next cycle; rx_valid still 1 until rx_ready.
- GAP_CYCLES=2, two back-to-back words with tx_valid held -> tx_ready low for 2 cycles after each CAPTURE; second handshake 13 cycles after the first.
- abort in the 4th SHIFT cycle of 0xFF -> next cycle IDLE: busy=0, sr_shift_en=0, rx_valid unchanged, overrun unchanged; a new word is then accepted normally.
- rst_n=0 for one edge mid-SHIFT -> all outputs at reset values the next cycle; no rx_valid; tx_ready=1.
